mem_req_scheduler: RTL and testbench
====================================

Name: mem_req_scheduler

Overview:
Round-robin scheduler that shares one memory request/response port between NUM_REQS requesters (e.g. per-cluster memory buses ahead of the L3/memory interface). It appends the requester index to the outgoing tag, routes responses back by that index, and limits outstanding reads per requester with a credit counter. One registered request stage on the output.

Parameters:
NUM_REQS, 4, number of requesters (must be >= 2)
ADDR_WIDTH, 26, line address width
DATA_WIDTH, 512, line data width; byte-enable width is DATA_WIDTH/8
TAG_IN_WIDTH, 8, requester tag width
MAX_PENDING, 16, max outstanding reads per requester (>= 1)
REQ_SEL_BITS (derived), $clog2(NUM_REQS); TAG_OUT_WIDTH = TAG_IN_WIDTH + REQ_SEL_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_req_valid  in  NUM_REQS  per-requester request valid
in_req_rw  in  NUM_REQS  1 = write, 0 = read
in_req_byteen  in  NUM_REQS x DATA_WIDTH/8  byte enables
in_req_addr  in  NUM_REQS x ADDR_WIDTH  address
in_req_data  in  NUM_REQS x DATA_WIDTH  write data
in_req_tag  in  NUM_REQS x TAG_IN_WIDTH  request tag
in_req_ready  out  NUM_REQS  request accepted when valid && ready
in_rsp_valid  out  NUM_REQS  response valid (one-hot or zero)
in_rsp_data  out  DATA_WIDTH  response data, shared by all requesters
in_rsp_tag  out  TAG_IN_WIDTH  response tag with index stripped
in_rsp_ready  in  NUM_REQS  per-requester response ready
mem_req_valid  out  1  registered request valid
mem_req_rw / mem_req_byteen / mem_req_addr / mem_req_data  out  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  registered request fields
mem_req_tag  out  TAG_OUT_WIDTH  {in_req_tag, requester index}; index in LSBs
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  memory response valid
mem_rsp_data  in  DATA_WIDTH  response data
mem_rsp_tag  in  TAG_OUT_WIDTH  response tag
mem_rsp_ready  out  1  response accepted
busy  out  1  any read pending or output stage occupied
err_underflow  out  1  sticky: response for requester with zero pending reads

Behaviour:
- Reset: mem_req_valid=0, all pending counters=0, RR pointer=0, err_underflow=0; in_req_ready=0 while reset asserted; output stage fields don't-care.
- Eligibility: requester i eligible = in_req_valid[i] && (in_req_rw[i] || pending[i] < MAX_PENDING).
- Arbitration: pick first eligible index scanning ptr, ptr+1, ... modulo NUM_REQS. Stage can load when !mem_req_valid || mem_req_ready. in_req_ready[i] = (i == winner) && any eligible && stage can load; at most one ready bit high per cycle.
- On accept: output stage loads winner fields next cycle (latency 1); ptr <= (winner+1) mod NUM_REQS. No accept -> ptr unchanged.
- Output stage: mem_req_valid holds with stable fields until mem_req_ready; a new accept in the same cycle as mem_req_ready gives back-to-back valid (full throughput, one per cycle). Ready dropping never changes held fields.
- Responses (combinational, no buffering): idx = mem_rsp_tag[REQ_SEL_BITS-1:0]; in_rsp_valid[idx] = mem_rsp_valid; in_rsp_tag = mem_rsp_tag upper bits; mem_rsp_ready = in_rsp_ready[idx]. idx >= NUM_REQS (non-power-of-2): response dropped (mem_rsp_ready=1), err_underflow set.
- Pending[i], width $clog2(MAX_PENDING+1): +1 on read accept for i, -1 on response fire for i; both same cycle -> unchanged. Writes don't count. Decrement at 0: counter stays 0, err_underflow <= 1 (cleared only by reset).
- busy = mem_req_valid || (any pending != 0).
- Reset mid-operation: held request and all pending credits discarded; responses after reset are treated as underflow.

Test Plan:
- Single read: req 2 valid, tag 0x5A, addr 0x100 -> next cycle mem_req_valid=1, addr 0x100, tag {0x5A,2'd2}; pending[2]=1, busy=1; response tag {0x5A,2} -> in_rsp_valid=4'b0100, in_rsp_tag 0x5A, pending[2]=0, busy=0.
- Fairness: all 4 requesters valid continuously, mem_req_ready=1 -> grant order 0,1,2,3,0,... one request per cycle, no gaps.
- Credits: MAX_PENDING=2, requester 1 issues 3 reads, no responses -> third held (in_req_ready[1]=0), others still granted; one response -> third accepted next arbitration.
- Backpressure: mem_req_ready=0 for 5 cycles with valid held -> fields stable, all in_req_ready=0; ready=1 -> transfer, next winner loads same cycle.
- Simultaneous: read accept and response for requester 0 in same cycle with pending=1 -> pending stays 1.
- Underflow: response tag index 3 with pending[3]=0 -> err_underflow=1, stays 1 until reset; reset -> 0.

Source files
------------

// File: rtl/mem_req_scheduler_if.sv
// Bus bundle between the requesters, the scheduler and the memory port.
// slave = scheduler side; master = the requester/memory environment around it.
interface mem_req_scheduler_if #(
    parameter int unsigned NUM_REQS      = 4,
    parameter int unsigned ADDR_WIDTH    = 26,
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned TAG_IN_WIDTH  = 8,
    parameter int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + $clog2(NUM_REQS)
) ();
    logic [NUM_REQS-1:0]                     in_req_valid;
    logic [NUM_REQS-1:0]                     in_req_rw;
    logic [NUM_REQS-1:0][DATA_WIDTH/8-1:0]   in_req_byteen;
    logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]     in_req_addr;
    logic [NUM_REQS-1:0][DATA_WIDTH-1:0]     in_req_data;
    logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]   in_req_tag;
    logic [NUM_REQS-1:0]                     in_req_ready;

    logic [NUM_REQS-1:0]                     in_rsp_valid;
    logic [DATA_WIDTH-1:0]                   in_rsp_data;
    logic [TAG_IN_WIDTH-1:0]                 in_rsp_tag;
    logic [NUM_REQS-1:0]                     in_rsp_ready;

    logic                                    mem_req_valid;
    logic                                    mem_req_rw;
    logic [DATA_WIDTH/8-1:0]                 mem_req_byteen;
    logic [ADDR_WIDTH-1:0]                   mem_req_addr;
    logic [DATA_WIDTH-1:0]                   mem_req_data;
    logic [TAG_OUT_WIDTH-1:0]                mem_req_tag;
    logic                                    mem_req_ready;

    logic                                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]                   mem_rsp_data;
    logic [TAG_OUT_WIDTH-1:0]                mem_rsp_tag;
    logic                                    mem_rsp_ready;

    modport slave (
        input  in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        output in_req_ready,
        output in_rsp_valid, in_rsp_data, in_rsp_tag,
        input  in_rsp_ready,
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data,
        output mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport master (
        output in_req_valid, in_req_rw, in_req_byteen, in_req_addr, in_req_data, in_req_tag,
        input  in_req_ready,
        input  in_rsp_valid, in_rsp_data, in_rsp_tag,
        output in_rsp_ready,
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data,
        input  mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/mem_req_scheduler.sv
// Round-robin arbiter sharing one memory port between NUM_REQS requesters, with
// per-requester read credits, tag-index response routing and a registered request stage.
module mem_req_scheduler #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned TAG_IN_WIDTH = 8,
    parameter int unsigned MAX_PENDING  = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_req_scheduler_if.slave bus,
    output logic               busy,
    output logic               err_underflow
);
    localparam int unsigned ReqSelBits  = $clog2(NUM_REQS);
    localparam int unsigned TagOutWidth = TAG_IN_WIDTH + ReqSelBits;
    localparam int unsigned CntWidth    = $clog2(MAX_PENDING + 1);
    localparam int unsigned BeWidth     = DATA_WIDTH / 8;

    typedef logic [CntWidth-1:0] cnt_t;

    cnt_t                    pending_q [NUM_REQS];
    cnt_t                    pending_d [NUM_REQS];
    logic [ReqSelBits-1:0]   ptr_q, ptr_d;
    logic                    err_q, err_d;

    logic                    req_valid_q, req_valid_d;
    logic                    req_rw_q, req_rw_d;
    logic [BeWidth-1:0]      req_byteen_q, req_byteen_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
    logic [TagOutWidth-1:0]  req_tag_q, req_tag_d;

    logic [NUM_REQS-1:0]     eligible;
    logic [NUM_REQS-1:0]     req_ready;
    logic [NUM_REQS-1:0]     rd_inc;
    logic [NUM_REQS-1:0]     rsp_dec;
    logic [ReqSelBits-1:0]   winner, cand, rsp_idx;
    logic                    found, stage_load, accept;
    logic                    rsp_in_range, rsp_fire, any_pending;

    // Arbitration: first eligible requester at or after the round-robin pointer.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            eligible[i] = bus.in_req_valid[i] &&
                          (bus.in_req_rw[i] || (pending_q[i] < cnt_t'(MAX_PENDING)));
        end
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            cand = ReqSelBits'((32'(ptr_q) + k) % NUM_REQS);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        stage_load = !req_valid_q || bus.mem_req_ready;
        accept     = found && stage_load && !reset;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = accept && (winner == ReqSelBits'(i));
        end
        ptr_d = accept ? ReqSelBits'((32'(winner) + 1) % NUM_REQS) : ptr_q;
    end

    always_comb begin
        req_valid_d  = req_valid_q && !bus.mem_req_ready;
        req_rw_d     = req_rw_q;
        req_byteen_d = req_byteen_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_tag_d    = req_tag_q;
        if (accept) begin
            req_valid_d  = 1'b1;
            req_rw_d     = bus.in_req_rw[winner];
            req_byteen_d = bus.in_req_byteen[winner];
            req_addr_d   = bus.in_req_addr[winner];
            req_data_d   = bus.in_req_data[winner];
            req_tag_d    = {bus.in_req_tag[winner], winner};
        end
    end

    // Indices past NUM_REQS only exist when NUM_REQS is not a power of two.
    if (NUM_REQS == (1 << ReqSelBits)) begin : g_pow2
        assign rsp_in_range = 1'b1;
    end else begin : g_npow2
        assign rsp_in_range = (32'(rsp_idx) < NUM_REQS);
    end

    always_comb begin
        rsp_idx           = bus.mem_rsp_tag[ReqSelBits-1:0];
        bus.in_rsp_valid  = '0;
        bus.mem_rsp_ready = 1'b1;
        if (rsp_in_range) begin
            bus.in_rsp_valid[rsp_idx] = bus.mem_rsp_valid;
            bus.mem_rsp_ready         = bus.in_rsp_ready[rsp_idx];
        end
        rsp_fire = bus.mem_rsp_valid && bus.mem_rsp_ready;
    end

    // Credit counters; a same-cycle issue and return cancel out.
    always_comb begin
        err_d       = err_q;
        any_pending = 1'b0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            rd_inc[i]    = req_ready[i] && !bus.in_req_rw[i];
            rsp_dec[i]   = rsp_fire && rsp_in_range && (rsp_idx == ReqSelBits'(i));
            pending_d[i] = pending_q[i];
            if (rd_inc[i] && !rsp_dec[i]) begin
                pending_d[i] = pending_q[i] + cnt_t'(1);
            end else if (rsp_dec[i] && !rd_inc[i]) begin
                if (pending_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    pending_d[i] = pending_q[i] - cnt_t'(1);
                end
            end
            if (pending_q[i] != '0) begin
                any_pending = 1'b1;
            end
        end
        if (rsp_fire && !rsp_in_range) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q <= 1'b0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                pending_q[i] <= '0;
            end
        end else begin
            req_valid_q <= req_valid_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            for (int unsigned i = 0; i < NUM_REQS; i++) begin
                pending_q[i] <= pending_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        req_rw_q     <= req_rw_d;
        req_byteen_q <= req_byteen_d;
        req_addr_q   <= req_addr_d;
        req_data_q   <= req_data_d;
        req_tag_q    <= req_tag_d;
    end

    assign bus.in_req_ready   = req_ready;
    assign bus.in_rsp_data    = bus.mem_rsp_data;
    assign bus.in_rsp_tag     = bus.mem_rsp_tag[TagOutWidth-1:ReqSelBits];
    assign bus.mem_req_valid  = req_valid_q;
    assign bus.mem_req_rw     = req_rw_q;
    assign bus.mem_req_byteen = req_byteen_q;
    assign bus.mem_req_addr   = req_addr_q;
    assign bus.mem_req_data   = req_data_q;
    assign bus.mem_req_tag    = req_tag_q;
    assign busy               = req_valid_q || any_pending;
    assign err_underflow      = err_q;
endmodule

// File: tb/tb_mem_req_scheduler.sv
// Self-checking bench for mem_req_scheduler: reset-state vector table, directed
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_mem_req_scheduler;
    localparam int unsigned NR  = 4;
    localparam int unsigned AW  = 26;
    localparam int unsigned DW  = 32;
    localparam int unsigned TW  = 8;
    localparam int unsigned MP  = 2;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned TOW = TW + 2;

    logic clk = 1'b0;
    logic rst;
    logic busy, err_underflow;

    always #5 clk = ~clk;

    mem_req_scheduler_if #(
        .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)
    ) bus ();

    mem_req_scheduler #(
        .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW), .MAX_PENDING(MP)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus),
        .busy(busy),
        .err_underflow(err_underflow)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int             m_pend [NR];
    int             m_ptr = 0;
    bit             m_ov  = 1'b0;
    bit             m_err = 1'b0;
    logic           m_rw;
    logic [BW-1:0]  m_be;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_data;
    logic [TOW-1:0] m_tag;

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] rw;
        logic       rv;
        logic [9:0] rtag;
        logic [3:0] rrdy;
        logic [3:0] e_ready;
        logic [3:0] e_rsp;
        logic [7:0] e_tag;
        logic       e_mrdy;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, want);
        end
    endtask

    task automatic clear_inputs();
        bus.in_req_valid  = '0;
        bus.in_req_rw     = '0;
        bus.in_req_byteen = '0;
        bus.in_req_addr   = '0;
        bus.in_req_data   = '0;
        bus.in_req_tag    = '0;
        bus.in_rsp_ready  = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_tag   = '0;
    endtask

    // Predict this cycle's outputs, compare, then advance the model across the clock edge.
    task automatic step();
        int         w;
        int         idx;
        int         net;
        bit         found, acc, fire, exp_busy;
        logic [3:0] er;
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (!found && bus.in_req_valid[i] && (bus.in_req_rw[i] || m_pend[i] < MP)) begin
                found = 1'b1;
                w     = i;
            end
        end
        acc      = found && (!m_ov || bus.mem_req_ready) && !rst;
        er       = acc ? 4'(1 << w) : 4'b0;
        idx      = int'(bus.mem_rsp_tag) % NR;
        fire     = bus.mem_rsp_valid && bus.in_rsp_ready[idx];
        exp_busy = m_ov;
        for (int i = 0; i < NR; i++) if (m_pend[i] != 0) exp_busy = 1'b1;
        #3;
        chk("in_req_ready", 64'(bus.in_req_ready), 64'(er));
        chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(m_ov));
        if (m_ov) begin
            chk("mem_req_rw", 64'(bus.mem_req_rw), 64'(m_rw));
            chk("mem_req_byteen", 64'(bus.mem_req_byteen), 64'(m_be));
            chk("mem_req_addr", 64'(bus.mem_req_addr), 64'(m_addr));
            chk("mem_req_data", 64'(bus.mem_req_data), 64'(m_data));
            chk("mem_req_tag", 64'(bus.mem_req_tag), 64'(m_tag));
        end
        chk("in_rsp_valid", 64'(bus.in_rsp_valid),
            bus.mem_rsp_valid ? 64'(1 << idx) : 64'(0));
        chk("in_rsp_tag", 64'(bus.in_rsp_tag), 64'(bus.mem_rsp_tag >> 2));
        if (bus.mem_rsp_valid) chk("in_rsp_data", 64'(bus.in_rsp_data), 64'(bus.mem_rsp_data));
        chk("mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(bus.in_rsp_ready[idx]));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
        @(posedge clk);
        if (rst) begin
            m_ov  = 1'b0;
            m_err = 1'b0;
            m_ptr = 0;
            for (int i = 0; i < NR; i++) m_pend[i] = 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                net = ((acc && w == i && !bus.in_req_rw[i]) ? 1 : 0) - ((fire && idx == i) ? 1 : 0);
                if (net < 0 && m_pend[i] == 0) m_err = 1'b1;
                else m_pend[i] += net;
            end
            if (acc) begin
                m_ov   = 1'b1;
                m_rw   = bus.in_req_rw[w];
                m_be   = bus.in_req_byteen[w];
                m_addr = bus.in_req_addr[w];
                m_data = bus.in_req_data[w];
                m_tag  = {bus.in_req_tag[w], 2'(w)};
                m_ptr  = (w + 1) % NR;
            end else if (bus.mem_req_ready) begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin : main
        int idx;
        int start;
        vecs[0] = '{v: 4'b0001, rw: 4'b0000, rv: 1'b0, rtag: 10'h000, rrdy: 4'b0000,
                    e_ready: 4'b0001, e_rsp: 4'b0000, e_tag: 8'h00, e_mrdy: 1'b0};
        vecs[1] = '{v: 4'b1010, rw: 4'b0000, rv: 1'b1, rtag: 10'h16A, rrdy: 4'b0100,
                    e_ready: 4'b0010, e_rsp: 4'b0100, e_tag: 8'h5A, e_mrdy: 1'b1};
        vecs[2] = '{v: 4'b1100, rw: 4'b1100, rv: 1'b1, rtag: 10'h0F3, rrdy: 4'b0111,
                    e_ready: 4'b0100, e_rsp: 4'b1000, e_tag: 8'h3C, e_mrdy: 1'b0};
        vecs[3] = '{v: 4'b0000, rw: 4'b0000, rv: 1'b1, rtag: 10'h3FC, rrdy: 4'b0001,
                    e_ready: 4'b0000, e_rsp: 4'b0001, e_tag: 8'hFF, e_mrdy: 1'b1};
        vecs[4] = '{v: 4'b1000, rw: 4'b1000, rv: 1'b0, rtag: 10'h3C1, rrdy: 4'b1111,
                    e_ready: 4'b1000, e_rsp: 4'b0000, e_tag: 8'hF0, e_mrdy: 1'b1};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state: no ready while reset is held even with all requesters valid
        bus.in_req_valid = 4'b1111;
        rst = 1'b1;
        #1 chk("reset_ready", 64'(bus.in_req_ready), 64'(0));
        step();
        do_reset();

        // Vector table, each applied from a fresh reset state
        for (int n = 0; n < 5; n++) begin
            do_reset();
            bus.in_req_valid  = vecs[n].v;
            bus.in_req_rw     = vecs[n].rw;
            bus.mem_rsp_valid = vecs[n].rv;
            bus.mem_rsp_tag   = vecs[n].rtag;
            bus.in_rsp_ready  = vecs[n].rrdy;
            #2;
            chk("vec_ready", 64'(bus.in_req_ready), 64'(vecs[n].e_ready));
            chk("vec_rsp_valid", 64'(bus.in_rsp_valid), 64'(vecs[n].e_rsp));
            chk("vec_rsp_tag", 64'(bus.in_rsp_tag), 64'(vecs[n].e_tag));
            chk("vec_mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'(vecs[n].e_mrdy));
        end
        do_reset();

        // Single read from requester 2
        bus.in_req_valid   = 4'b0100;
        bus.in_req_tag[2]  = 8'h5A;
        bus.in_req_addr[2] = 26'h100;
        bus.in_req_data[2] = 32'hCAFE_0002;
        step();
        bus.in_req_valid = '0;
        chk("single_valid", 64'(bus.mem_req_valid), 64'(1));
        chk("single_addr", 64'(bus.mem_req_addr), 64'h100);
        chk("single_tag", 64'(bus.mem_req_tag), 64'h16A);
        chk("single_busy", 64'(busy), 64'(1));
        bus.mem_req_ready = 1'b1;
        step();
        chk("single_busy_pending", 64'(busy), 64'(1));
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = 10'h16A;
        bus.in_rsp_ready  = 4'b1111;
        #1;
        chk("single_rsp_valid", 64'(bus.in_rsp_valid), 64'b0100);
        chk("single_rsp_tag", 64'(bus.in_rsp_tag), 64'h5A);
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("single_idle", 64'(busy), 64'(0));

        // Fairness: continuous writes from everyone, full throughput
        do_reset();
        bus.in_req_valid  = 4'b1111;
        bus.in_req_rw     = 4'b1111;
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < NR; i++) bus.in_req_tag[i] = 8'(8'h10 + i);
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_grant", 64'(bus.in_req_ready), 64'(1 << (k % 4)));
            step();
            chk("fair_out_valid", 64'(bus.mem_req_valid), 64'(1));
            chk("fair_out_idx", 64'(bus.mem_req_tag[1:0]), 64'(k % 4));
        end

        // Credits: requester 1 reads until out of credit while 3 keeps writing
        do_reset();
        bus.in_req_valid  = 4'b1010;
        bus.in_req_rw     = 4'b1000;
        bus.mem_req_ready = 1'b1;
        bus.in_rsp_ready  = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            bus.mem_rsp_valid = (c == 5);
            bus.mem_rsp_tag   = {8'h11, 2'd1};
            #1;
            if (c == 4) chk("credit_held", 64'(bus.in_req_ready), 64'b1000);
            if (c == 6) chk("credit_release", 64'(bus.in_req_ready), 64'b0010);
            step();
        end
        bus.mem_rsp_valid = 1'b0;

        // Backpressure: held request stays stable while memory stalls
        do_reset();
        bus.in_req_valid   = 4'b0001;
        bus.in_req_addr[0] = 26'h2AA_AAAA;
        bus.in_req_data[0] = 32'h1234_5678;
        step();
        bus.in_req_valid   = 4'b0110;
        bus.in_req_rw      = 4'b0110;
        bus.in_req_addr[0] = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 64'(bus.in_req_ready), 64'(0));
            chk("bp_addr", 64'(bus.mem_req_addr), 64'h2AA_AAAA);
            step();
        end
        bus.mem_req_ready = 1'b1;
        #1 chk("bp_release", 64'(bus.in_req_ready), 64'b0010);
        step();
        chk("bp_next_idx", 64'(bus.mem_req_tag[1:0]), 64'(1));

        // Simultaneous read issue and response for requester 0
        do_reset();
        bus.in_req_valid  = 4'b0001;
        bus.mem_req_ready = 1'b1;
        bus.in_rsp_ready  = 4'b1111;
        step();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = {8'h22, 2'd0};
        step();
        bus.in_req_valid  = '0;
        bus.mem_rsp_valid = 1'b0;
        step();
        chk("simul_busy", 64'(busy), 64'(1));
        bus.mem_rsp_valid = 1'b1;
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("simul_drained", 64'(busy), 64'(0));

        // Underflow: response for requester with no pending reads
        do_reset();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = {8'h33, 2'd3};
        bus.in_rsp_ready  = 4'b1111;
        step();
        bus.mem_rsp_valid = 1'b0;
        chk("uflow_set", 64'(err_underflow), 64'(1));
        repeat (3) step();
        chk("uflow_sticky", 64'(err_underflow), 64'(1));
        do_reset();
        chk("uflow_clear", 64'(err_underflow), 64'(0));

        // Randomized traffic, responses mostly aimed at requesters with credits out
        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.in_req_valid = 4'($urandom);
            bus.in_req_rw    = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                bus.in_req_byteen[i] = BW'($urandom);
                bus.in_req_addr[i]   = AW'($urandom);
                bus.in_req_data[i]   = $urandom;
                bus.in_req_tag[i]    = 8'($urandom);
            end
            bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            bus.mem_rsp_valid = 1'($urandom_range(0, 1));
            idx   = int'($urandom_range(0, NR - 1));
            start = idx;
            if ($urandom_range(0, 7) != 0) begin
                for (int t = NR - 1; t >= 0; t--) begin
                    if (m_pend[(start + t) % NR] > 0) idx = (start + t) % NR;
                end
            end
            bus.mem_rsp_tag  = {8'($urandom), 2'(idx)};
            bus.mem_rsp_data = $urandom;
            bus.in_rsp_ready = 4'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
